rs_syndrome_gen: RTL



---
 rtl/rs_gf_pkg.sv | 49 ++++
 rtl/rs_gf_const_mul.sv | 13 +
 rtl/rs_syndrome_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rs_gf_pkg.sv
// GF(2^8) arithmetic over primitive polynomial 0x11D, shared by the Reed-Solomon front end.
// Helpers are elaboration-time functions used to derive constant multiplier coefficients.
package rs_gf_pkg;

    localparam logic [8:0] PRIM_POLY = 9'h11D;
    localparam int         MAX_NSYM  = 16;

    typedef enum logic [1:0] {IDLE, DATA, PARITY} rsState_t;

    // Generator coefficients, index i is the x^i term; entry NSYM is the monic 1.
    typedef logic [MAX_NSYM:0][7:0] coefVec_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? PRIM_POLY[7:0] : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gf_pow(input logic [7:0] alpha, input int k);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 255; i++) begin
            if (i < (k % 255)) r = gf_mul(r, alpha);
        end
        return r;
    endfunction

    function automatic coefVec_t gen_poly(input int nsym, input int fcr);
        coefVec_t   g;
        logic [7:0] root;
        g    = '0;
        g[0] = 8'h01;
        for (int j = 0; j < MAX_NSYM; j++) begin
            if (j < nsym) begin
                root = gf_pow(8'h02, fcr + j);
                for (int i = MAX_NSYM; i > 0; i--) g[i] = g[i-1] ^ gf_mul(g[i], root);
                g[0] = gf_mul(g[0], root);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rs_gf_const_mul.sv
// Multiply a byte by a fixed GF(2^8) coefficient; folds to a small XOR network.
module rs_gf_const_mul
    import rs_gf_pkg::*;
#(
    parameter logic [7:0] COEF = 8'h01
) (
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = gf_mul(a, COEF);

endmodule

// File: rtl/rs_syndrome_gen.sv
// Reed-Solomon front end: NSYM syndromes per segment (decode) or systematic parity append (encode).
module rs_syndrome_gen
    import rs_gf_pkg::*;
#(
    parameter int NSYM   = 4,
    parameter int FCR    = 0,
    parameter int MAXLEN = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              encoding,
    input  logic              start,
    input  logic              abort,
    input  logic              endSegment,
    input  logic [7:0]        dataI,
    input  logic              dataIValid,
    output logic              dataRequest,
    output logic [7:0]        dataO,
    output logic              dataValid,
    output logic [8*NSYM-1:0] syn,
    output logic              synReady,
    output logic              synZero,
    output logic              lenError
);

    localparam coefVec_t   GEN      = gen_poly(NSYM, FCR);
    localparam logic [7:0] LIM_DEC  = 8'(MAXLEN);
    localparam logic [7:0] LIM_ENC  = 8'(MAXLEN - NSYM);
    localparam logic [4:0] PAR_LAST = 5'(NSYM - 1);

    rsState_t state, stateNext;

    logic [NSYM-1:0][7:0] synReg, synNext, synMul;
    logic [NSYM-1:0][7:0] lfsr, tapMul;
    logic [7:0]           fb, cnt, cntNext;
    logic [4:0]           parCnt;
    logic                 encMode, init;
    logic                 accept, startSeg, doClear, synDone, lenErrNext, atLimit;

    assign dataRequest = (state == DATA);
    assign accept      = dataRequest & dataIValid;
    assign fb          = dataI ^ lfsr[NSYM-1];
    assign cntNext     = cnt + 8'd1;
    assign atLimit     = (cntNext == (encMode ? LIM_ENC : LIM_DEC));
    assign syn         = synReg;

    // One Horner multiplier and one LFSR tap per check symbol.
    for (genvar j = 0; j < NSYM; j++) begin : gLane
        rs_gf_const_mul #(.COEF(gf_pow(8'h02, FCR + j))) uHorner (.a(synReg[j]), .y(synMul[j]));
        rs_gf_const_mul #(.COEF(GEN[j]))                 uTap    (.a(fb),        .y(tapMul[j]));
        assign synNext[j] = init ? dataI : (synMul[j] ^ dataI);
    end

    always_comb begin
        stateNext  = state;
        startSeg   = 1'b0;
        doClear    = 1'b0;
        synDone    = 1'b0;
        lenErrNext = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = DATA;
                    startSeg  = 1'b1;
                end
            end
            DATA: begin
                if (accept) begin
                    if (endSegment) begin
                        if (encMode) begin
                            stateNext = PARITY;
                        end else begin
                            synDone   = 1'b1;
                            stateNext = start ? DATA : IDLE;
                            startSeg  = start;
                        end
                    end else if (atLimit) begin
                        lenErrNext = 1'b1;
                        doClear    = 1'b1;
                        stateNext  = IDLE;
                    end
                end
            end
            PARITY: begin
                if (parCnt == PAR_LAST) begin
                    stateNext = start ? DATA : IDLE;
                    startSeg  = start;
                end
            end
            default: stateNext = IDLE;
        endcase
        // abort overrides everything, including a coincident start or length error
        if (abort) begin
            stateNext  = IDLE;
            doClear    = 1'b1;
            startSeg   = 1'b0;
            synDone    = 1'b0;
            lenErrNext = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            synReg    <= '0;
            lfsr      <= '0;
            cnt       <= '0;
            parCnt    <= '0;
            encMode   <= 1'b0;
            init      <= 1'b0;
            dataO     <= '0;
            dataValid <= 1'b0;
            synReady  <= 1'b0;
            synZero   <= 1'b0;
            lenError  <= 1'b0;
        end else begin
            state     <= stateNext;
            synReady  <= synDone;
            lenError  <= lenErrNext;
            dataValid <= 1'b0;
            if (doClear) begin
                synReg  <= '0;
                lfsr    <= '0;
                synZero <= 1'b0;
            end else if (accept) begin
                dataO     <= dataI;
                dataValid <= 1'b1;
                cnt       <= cntNext;
                init      <= 1'b0;
                parCnt    <= '0;
                if (encMode) begin
                    lfsr[0] <= tapMul[0];
                    for (int i = 1; i < NSYM; i++) lfsr[i] <= lfsr[i-1] ^ tapMul[i];
                end else begin
                    synReg <= synNext;
                    if (endSegment) synZero <= (synNext == '0);
                end
            end else if (state == PARITY) begin
                dataO     <= lfsr[NSYM-1];
                dataValid <= 1'b1;
                lfsr      <= {lfsr[NSYM-2:0], 8'h00};
                parCnt    <= parCnt + 5'd1;
            end
            // syn is left alone here so the previous result stays visible until new data lands
            if (startSeg) begin
                encMode <= encoding;
                cnt     <= '0;
                init    <= 1'b1;
                lfsr    <= '0;
            end
        end
    end

endmodule
